uart_rx_cfg: RTL and testbench

Parametrised second-generation UART receiver: oversampled serial input to parallel word, with run-time parity/stop-bit configuration and explicit parity and framing error reporting. It sits in the same receive path as the existing 8-bit receiver, clocked at Prescale × baud. It adds configurable data width, optional second stop bit, input synchronisation, start-glitch rejection and back-to-back frame acceptance.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 69 ++++++
 rtl/uart_rx_cfg.sv | 130 +++++++++++++
 tb/tb_uart_rx_cfg.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the configurable UART receiver:
// the receive FSM states, parity selectors and the parity/majority functions.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_STOP2
  } rx_state_t;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam int   MAX_DATA_W = 9;

  // Zero-extension of narrower words leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input logic                  par_typ);
    return (par_typ == PAR_ODD) ? ~^data : ^data;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, per-bit edge counter and bit sampler for uart_rx_cfg.
// UART_RX_CFG_MAJORITY_EN selects 3-sample majority voting around the sample point.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  i_active,
  input  logic [PRESCALE_W-1:0] i_presc,
  output logic                  o_rx_s,
  output logic                  sampled_bit,
  output logic                  bit_done,
  output logic                  sample_valid
);

  logic                  r_sync1;
  logic                  r_rx_s;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [PRESCALE_W-1:0] w_sp;
  logic                  r_s_mid;

  assign w_sp         = i_presc >> 1;
  assign o_rx_s       = r_rx_s;
  assign bit_done     = i_active && (r_edge_cnt == i_presc - PRESCALE_W'(1));
  assign sample_valid = i_active && (r_edge_cnt == w_sp + PRESCALE_W'(1));

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_edge_cnt <= '0;
    else if (!i_active || bit_done)
      r_edge_cnt <= '0;
    else
      r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (r_edge_cnt == w_sp)
      r_s_mid <= r_rx_s;
  end

`ifdef UART_RX_CFG_MAJORITY_EN
  logic r_s_early;

  always_ff @(posedge CLK) begin
    if (r_edge_cnt == w_sp - PRESCALE_W'(1))
      r_s_early <= r_rx_s;
  end

  // Third vote is the live sample at SP+1, the same cycle the decision is taken.
  assign sampled_bit = maj3(r_s_early, r_s_mid, r_rx_s);
`else
  assign sampled_bit = r_s_mid;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity, 1/2 stop bits, error pulses.
// Build with UART_RX_CFG_MAJORITY_EN for majority-vote bit sampling.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  rx_busy
);

  rx_state_t             r_state, w_next;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  r_par_en, r_par_typ, r_stop2;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [3:0]            r_bit_cnt;
  logic                  r_par_err, r_stop_err;
  logic                  w_rx_s, w_bit, w_bit_done, w_sample_valid;
  logic                  w_active, w_finish, w_last_data, w_ferr, w_good;

  assign w_active    = (r_state != ST_IDLE);
  assign rx_busy     = w_active;
  assign w_last_data = (r_bit_cnt == 4'(DATA_WIDTH - 1));
  assign w_ferr      = r_stop_err | ~w_bit;
  assign w_good      = ~w_ferr & ~r_par_err;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .i_active     (w_active),
    .i_presc      (r_presc),
    .o_rx_s       (w_rx_s),
    .sampled_bit  (w_bit),
    .bit_done     (w_bit_done),
    .sample_valid (w_sample_valid)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Stop states return to IDLE at the decision point so a new start edge
  // in the back half of the stop bit is caught.
  always_comb begin
    w_next   = r_state;
    w_finish = 1'b0;
    case (r_state)
      ST_IDLE:   if (!w_rx_s) w_next = ST_START;
      ST_START:  if (w_sample_valid && w_bit) w_next = ST_IDLE;
                 else if (w_bit_done)         w_next = ST_DATA;
      ST_DATA:   if (w_bit_done && w_last_data) w_next = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_done) w_next = ST_STOP;
      ST_STOP: begin
        if (r_stop2) begin
          if (w_bit_done) w_next = ST_STOP2;
        end else if (w_sample_valid) begin
          w_next   = ST_IDLE;
          w_finish = 1'b1;
        end
      end
      ST_STOP2: if (w_sample_valid) begin
        w_next   = ST_IDLE;
        w_finish = 1'b1;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_presc       <= '0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_stop2       <= 1'b0;
      r_bit_cnt     <= '0;
      r_par_err     <= 1'b0;
      r_stop_err    <= 1'b0;
      P_DATA        <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      if (r_state == ST_IDLE && !w_rx_s) begin
        r_presc   <= Prescale;
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
        r_stop2   <= STOP2;
      end
      if (r_state == ST_START) begin
        r_bit_cnt  <= '0;
        r_par_err  <= 1'b0;
        r_stop_err <= 1'b0;
      end
      if (r_state == ST_DATA && w_bit_done)
        r_bit_cnt <= r_bit_cnt + 4'd1;
      if (r_state == ST_PARITY && w_sample_valid)
        r_par_err <= (w_bit != calc_parity(MAX_DATA_W'(r_shift), r_par_typ));
      if ((r_state == ST_STOP || r_state == ST_STOP2) && w_sample_valid)
        r_stop_err <= w_ferr;
      if (w_finish) begin
        framing_error <= w_ferr;
        parity_error  <= r_par_err;
        data_valid    <= w_good;
        if (w_good) P_DATA <= r_shift;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (r_state == ST_DATA && w_sample_valid)
      r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed testbench for uart_rx_cfg: good frames at several prescales, parity,
// framing, start glitch, back-to-back two-stop frames, mid-frame reset.
module tb_uart_rx_cfg;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale;
  logic          PAR_EN, PAR_TYP, STOP2;
  logic [DW-1:0] P_DATA;
  logic          data_valid, parity_error, framing_error, rx_busy;

  int n_chk = 0;
  int n_err = 0;
  int dv_cnt = 0, pe_cnt = 0, fe_cnt = 0, wide_cnt = 0;
  logic [DW-1:0] dv_data [0:15];
  logic prev_dv = 1'b0, prev_pe = 1'b0, prev_fe = 1'b0;

  uart_rx_cfg #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .Prescale      (Prescale),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .STOP2         (STOP2),
    .P_DATA        (P_DATA),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  always #5 CLK = ~CLK;

  // Pulse monitor: counts outcome pulses, logs delivered words, flags any pulse wider than 1 CLK.
  always @(negedge CLK) begin
    if (data_valid) begin
      dv_data[dv_cnt[3:0]] = P_DATA;
      dv_cnt++;
    end
    if (parity_error)  pe_cnt++;
    if (framing_error) fe_cnt++;
    if ((data_valid && prev_dv) || (parity_error && prev_pe) || (framing_error && prev_fe))
      wide_cnt++;
    prev_dv = data_valid;
    prev_pe = parity_error;
    prev_fe = framing_error;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // len = 0 means a full bit; glitch inverts the line for one CLK near mid-bit.
  task automatic send_bit(input logic b, input bit glitch, input int len);
    int n;
    n = (len == 0) ? int'(Prescale) : len;
    for (int c = 0; c < n; c++) begin
      RX_IN = (glitch && c == int'(Prescale) / 2 + 1) ? ~b : b;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit bad_par, input bit bad_stop,
                            input bit glitch, input bit short_tail);
    int tail;
    tail = short_tail ? int'(Prescale) / 2 + 3 : 0;
    send_bit(1'b0, 1'b0, 0);
    for (int i = 0; i < DW; i++) send_bit(d[i], glitch, 0);
    if (PAR_EN) send_bit((PAR_TYP ? ~^d : ^d) ^ bad_par, 1'b0, 0);
    if (STOP2) begin
      send_bit(~bad_stop, 1'b0, 0);
      send_bit(1'b1, 1'b0, tail);
    end else begin
      send_bit(~bad_stop, 1'b0, tail);
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    Prescale = 6'd32;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b1;
    STOP2    = 1'b0;
    #12;
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_dv",    32'(data_valid), 32'h0);
    chk("rst_pe",    32'(parity_error), 32'h0);
    chk("rst_fe",    32'(framing_error), 32'h0);
    chk("rst_busy",  32'(rx_busy), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(4);

    // Odd parity 0xBB at three prescales
    for (int k = 0; k < 3; k++) begin
      Prescale = (k == 0) ? 6'd32 : (k == 1) ? 6'd16 : 6'd8;
      send_frame(8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2 * int'(Prescale));
      chk("bb_dv_cnt", dv_cnt, k + 1);
      chk("bb_pdata", 32'(P_DATA), 32'hBB);
    end
    chk("bb_no_pe", pe_cnt, 0);
    chk("bb_no_fe", fe_cnt, 0);

    // Even parity: good 0x3C, then 0xBB with inverted parity bit
    Prescale = 6'd16;
    PAR_TYP  = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(32);
    chk("even_dv_cnt", dv_cnt, 4);
    chk("even_pdata", 32'(P_DATA), 32'h3C);
    send_frame(8'hBB, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(32);
    chk("par_pe_cnt", pe_cnt, 1);
    chk("par_dv_cnt", dv_cnt, 4);
    chk("par_fe_cnt", fe_cnt, 0);
    chk("par_pdata_hold", 32'(P_DATA), 32'h3C);

    // No parity, stop bit low, then good 0x5C
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(16);
    chk("frm_fe_cnt", fe_cnt, 1);
    chk("frm_dv_cnt", dv_cnt, 4);
    chk("frm_pe_cnt", pe_cnt, 1);
    chk("frm_pdata_hold", 32'(P_DATA), 32'h3C);
    chk("frm_busy_idle", 32'(rx_busy), 32'h0);
    send_frame(8'h5C, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(16);
    chk("frm_good_dv_cnt", dv_cnt, 5);
    chk("frm_good_pdata", 32'(P_DATA), 32'h5C);

    // Start glitch: line low 4 CLK at prescale 16
    Prescale = 6'd16;
    RX_IN    = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK);
      #1;
    end
    RX_IN = 1'b1;
    chk("glitch_busy_hi", 32'(rx_busy), 32'h1);
    idle(12);
    chk("glitch_busy_lo", 32'(rx_busy), 32'h0);
    idle(20);
    chk("glitch_dv_cnt", dv_cnt, 5);
    chk("glitch_pe_cnt", pe_cnt, 1);
    chk("glitch_fe_cnt", fe_cnt, 1);

    // Two stop bits, back-to-back with next start mid second stop
    Prescale = 6'd8;
    STOP2    = 1'b1;
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(16);
    chk("b2b_dv_cnt", dv_cnt, 7);
    chk("b2b_word0", 32'(dv_data[5]), 32'hA3);
    chk("b2b_word1", 32'(dv_data[6]), 32'h3A);
    chk("b2b_fe_cnt", fe_cnt, 1);

    // Asynchronous reset in the middle of a 0xFF frame
    Prescale = 6'd16;
    STOP2    = 1'b0;
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    chk("pre_rst_busy", 32'(rx_busy), 32'h1);
    #3;
    RST = 1'b0;
    #1;
    chk("mid_rst_pdata", 32'(P_DATA), 32'h0);
    chk("mid_rst_busy",  32'(rx_busy), 32'h0);
    chk("mid_rst_dv",    32'(data_valid), 32'h0);
    RX_IN = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(32);
    chk("post_rst_dv_cnt", dv_cnt, 7);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(32);
    chk("post_rst_dv_cnt2", dv_cnt, 8);
    chk("post_rst_pdata", 32'(P_DATA), 32'h11);

`ifdef UART_RX_CFG_MAJORITY_EN
    // One-CLK glitch at the sample point of every data bit
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(32);
    chk("maj_dv_cnt", dv_cnt, 9);
    chk("maj_pdata", 32'(P_DATA), 32'h96);
`endif

    chk("pulse_width", wide_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
